// File: rtl/ddc_phase_loader.sv
// Streams the per-channel DDS phase table (PINC/POFF) to the DDS on commit,
// pulses resync, waits a settle time, then enables the DDC datapath.
module ddc_phase_loader #(
  parameter int N_CH          = 4,
  parameter int PHASE_W       = 32,
  parameter int SETTLE_CYCLES = 16,
  localparam int CH_W         = $clog2(N_CH),
  localparam int BW           = 2 * PHASE_W,
  localparam int CNT_W        = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_aresetn,
  input  logic               cfg_wr_en,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [PHASE_W-1:0] cfg_pinc,
  input  logic [PHASE_W-1:0] cfg_poff,
  input  logic               commit,
  output logic [BW-1:0]      m_axis_phase_tdata,
  output logic [CH_W-1:0]    m_axis_phase_tuser,
  output logic               m_axis_phase_tvalid,
  input  logic               m_axis_phase_tready,
  output logic               resync,
  output logic               ddc_en,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RESYNC = 3'd2,
    SETTLE = 3'd3,
    RUN    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              pending, pending_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [BW-1:0]     phase_tab [N_CH];
  logic              cap_en;
  logic [CH_W-1:0]   cap_idx;
  logic [BW-1:0]     cap_data;

  // Handshake: a beat transfers on a clock edge where tvalid && tready; while
  // tvalid is high and tready low, tdata/tuser are held unchanged.
  assign m_axis_phase_tvalid = (state == LOAD);
  assign resync              = (state == RESYNC);
  assign ddc_en              = (state == RUN);
  assign busy                = (state == LOAD) || (state == RESYNC) || (state == SETTLE);
  assign dbg_state           = state;

  // A write landing on the entry being captured wins over the stored value.
  assign cap_data = (cfg_wr_en && (cfg_ch == cap_idx)) ? {cfg_poff, cfg_pinc}
                                                       : phase_tab[cap_idx];

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    cnt_nxt     = cnt;
    cap_en      = 1'b0;
    cap_idx     = '0;
    case (state)
      IDLE, RUN: begin
        if (commit) begin
          state_nxt = LOAD;
          cap_en    = 1'b1;
        end
      end
      LOAD: begin
        if (commit) pending_nxt = 1'b1;
        if (m_axis_phase_tready) begin
          if (m_axis_phase_tuser == CH_W'(N_CH - 1)) begin
            state_nxt = RESYNC;
          end else begin
            cap_en  = 1'b1;
            cap_idx = m_axis_phase_tuser + CH_W'(1);
          end
        end
      end
      RESYNC: begin
        if (commit) pending_nxt = 1'b1;
        cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt == '0) begin
          if (pending || commit) begin
            state_nxt   = LOAD;
            pending_nxt = 1'b0;
            cap_en      = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          if (commit) pending_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state              <= IDLE;
      pending            <= 1'b0;
      cnt                <= '0;
      m_axis_phase_tdata <= '0;
      m_axis_phase_tuser <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      cnt     <= cnt_nxt;
      if (cap_en) begin
        m_axis_phase_tdata <= cap_data;
        m_axis_phase_tuser <= cap_idx;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      for (int i = 0; i < N_CH; i++) phase_tab[i] <= '0;
    end else if (cfg_wr_en) begin
      phase_tab[cfg_ch] <= {cfg_poff, cfg_pinc};
    end
  end

endmodule

// File: tb/tb_ddc_phase_loader.sv
// Bench for ddc_phase_loader: sequence-position reference model, per-cycle
// output compare, beat scoreboard, directed timing cases and random traffic.
module tb_ddc_phase_loader;

  localparam int N_CH    = 4;
  localparam int PHASE_W = 32;
  localparam int SETTLE  = 16;
  localparam int CH_W    = $clog2(N_CH);
  localparam int BW      = 2 * PHASE_W;
  localparam int CW      = BW + CH_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_wr_en = 1'b0;
  logic [CH_W-1:0]    cfg_ch = '0;
  logic [PHASE_W-1:0] cfg_pinc = '0;
  logic [PHASE_W-1:0] cfg_poff = '0;
  logic               commit = 1'b0;
  logic               tready = 1'b1;
  logic [BW-1:0]      tdata;
  logic [CH_W-1:0]    tuser;
  logic               tvalid;
  logic               resync;
  logic               ddc_en;
  logic               busy;
  logic [2:0]         dbg_state;

  ddc_phase_loader #(.N_CH(N_CH), .PHASE_W(PHASE_W), .SETTLE_CYCLES(SETTLE)) dut (
    .s_axis_aclk         (clk),
    .s_axis_aresetn      (rst_n),
    .cfg_wr_en           (cfg_wr_en),
    .cfg_ch              (cfg_ch),
    .cfg_pinc            (cfg_pinc),
    .cfg_poff            (cfg_poff),
    .commit              (commit),
    .m_axis_phase_tdata  (tdata),
    .m_axis_phase_tuser  (tuser),
    .m_axis_phase_tvalid (tvalid),
    .m_axis_phase_tready (tready),
    .resync              (resync),
    .ddc_en              (ddc_en),
    .busy                (busy),
    .dbg_state           (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Position in the commit sequence: 0..N_CH-1 beats, N_CH resync,
  // N_CH+1..N_CH+SETTLE settle cycles; after that RUN (or another load).
  logic [BW-1:0]   m_tab [N_CH];
  bit              m_active, m_run, m_pend;
  int              m_pos;
  logic [BW-1:0]   m_beat;
  logic [CH_W-1:0] m_user;
  logic [CW-1:0]   exp_q[$];
  logic [BW-1:0]   obs_q[$];

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) m_tab[i] = '0;
    m_active = 1'b0;
    m_run    = 1'b0;
    m_pend   = 1'b0;
    m_pos    = 0;
    m_beat   = '0;
    m_user   = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int cap;
    cap = -1;
    if (cfg_wr_en) m_tab[cfg_ch] = {cfg_poff, cfg_pinc};
    if (!m_active) begin
      if (commit) begin
        m_active = 1'b1;
        m_run    = 1'b0;
        m_pos    = 0;
        cap      = 0;
      end
    end else if (m_pos < N_CH) begin
      if (commit) m_pend = 1'b1;
      if (tready) begin
        m_pos++;
        if (m_pos < N_CH) cap = m_pos;
      end
    end else if (m_pos < N_CH + SETTLE) begin
      if (commit) m_pend = 1'b1;
      m_pos++;
    end else if (m_pend || commit) begin
      m_pend = 1'b0;
      m_pos  = 0;
      cap    = 0;
    end else begin
      m_active = 1'b0;
      m_run    = 1'b1;
    end
    if (cap >= 0) begin
      m_user = CH_W'(cap);
      m_beat = m_tab[cap];
      exp_q.push_back({m_user, m_beat});
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process ----------------
  int k_edge   = 0;
  int rs_cyc   = -1;
  int en_cyc   = -1;
  int rs_count = 0;
  bit en_prev  = 1'b0;

  initial begin
    logic [CW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("tvalid", CW'(tvalid), CW'(m_active && m_pos < N_CH));
        chk("resync", CW'(resync), CW'(m_active && m_pos == N_CH));
        chk("busy",   CW'(busy),   CW'(m_active));
        chk("ddc_en", CW'(ddc_en), CW'(m_run));
        chk("tdata",  CW'(tdata),  CW'(m_beat));
        chk("tuser",  CW'(tuser),  CW'(m_user));
        if (tvalid && tready) begin
          obs_q.push_back(tdata);
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_q: beat %0h accepted with no expected beat", tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {tuser, tdata}, e);
          end
        end
        if (resync) begin
          rs_count++;
          if (rs_cyc < 0) rs_cyc = cyc + 1;
        end
        if (ddc_en && !en_prev && en_cyc < 0) en_cyc = cyc + 1;
        en_prev = ddc_en;
      end else begin
        en_prev = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [PHASE_W-1:0] pinc, input logic [PHASE_W-1:0] poff);
    cfg_wr_en = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_pinc  = pinc;
    cfg_poff  = poff;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic start_commit();
    commit   = 1'b1;
    k_edge   = cyc + 1;
    rs_cyc   = -1;
    en_cyc   = -1;
    rs_count = 0;
    obs_q.delete();
    tick();
    commit = 1'b0;
  endtask

  task automatic wait_en(input int budget);
    int n;
    n = 0;
    while (en_cyc < 0 && n < budget) begin
      tick();
      n++;
    end
    n_tests++;
    if (en_cyc < 0) begin
      n_fail++;
      $display("FAIL wait_en: ddc_en not seen within %0d cycles", budget);
    end
  endtask

  task automatic chk_default_beats(input string name);
    logic [BW-1:0] exp_b;
    chk_int({name, "_nbeats"}, obs_q.size(), N_CH);
    for (int i = 0; i < N_CH && i < obs_q.size(); i++) begin
      exp_b = {PHASE_W'(32'h100 * i), PHASE_W'(32'h1000_0000 * (i + 1))};
      chk({name, "_beat"}, CW'(obs_q[i]), CW'(exp_b));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) tick();
    chk("rst_tvalid", CW'(tvalid), '0);
    chk("rst_tdata",  CW'(tdata),  '0);
    chk("rst_tuser",  CW'(tuser),  '0);
    chk("rst_resync", CW'(resync), '0);
    chk("rst_ddc_en", CW'(ddc_en), '0);
    chk("rst_busy",   CW'(busy),   '0);
    rst_n = 1'b1;
    tick();

    // Basic load with tready held high.
    for (int i = 0; i < N_CH; i++) wr(i, PHASE_W'(32'h1000_0000 * (i + 1)), PHASE_W'(32'h100 * i));
    start_commit();
    wait_en(100);
    chk_int("t1_resync_cyc", rs_cyc, k_edge + 5);
    chk_int("t1_en_cyc", en_cyc, k_edge + 22);
    chk_default_beats("t1");

    // Three stall cycles while beat 2 is presented.
    start_commit();
    tick();
    tick();
    tready = 1'b0;
    repeat (3) begin
      chk("t2_stall_tdata", CW'(tdata), CW'({32'h0000_0200, 32'h3000_0000}));
      tick();
    end
    tready = 1'b1;
    wait_en(100);
    chk_int("t2_resync_cyc", rs_cyc, k_edge + 8);
    chk_int("t2_en_cyc", en_cyc, k_edge + 25);
    chk_default_beats("t2");

    // Write to entry 0 in the same cycle as commit (also a commit from RUN).
    cfg_wr_en = 1'b1;
    cfg_ch    = '0;
    cfg_pinc  = 32'hDEAD_BEEF;
    cfg_poff  = 32'h1234_5678;
    start_commit();
    cfg_wr_en = 1'b0;
    chk("t3_en_drop", CW'(ddc_en), '0);
    wait_en(100);
    chk_int("t3_en_cyc", en_cyc, k_edge + 22);
    if (obs_q.size() > 0) chk("t3_bypass", CW'(obs_q[0]), CW'(64'h1234_5678_DEAD_BEEF));
    else chk_int("t3_nbeats", obs_q.size(), N_CH);

    // Two commits during SETTLE coalesce into a single reload.
    start_commit();
    n = 0;
    while (rs_cyc < 0 && n < 50) begin
      tick();
      n++;
    end
    chk_int("t4_resync_seen", (rs_cyc >= 0) ? 1 : 0, 1);
    repeat (3) tick();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (2) tick();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_en(200);
    chk_int("t4_en_cyc", en_cyc, k_edge + 43);
    chk_int("t4_resyncs", rs_count, 2);
    chk_int("t4_nbeats", obs_q.size(), 2 * N_CH);

    // Reset while beat 1 is presented.
    start_commit();
    tick();
    tready = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_tvalid", CW'(tvalid), '0);
    chk("t5_tdata",  CW'(tdata),  '0);
    chk("t5_tuser",  CW'(tuser),  '0);
    chk("t5_busy",   CW'(busy),   '0);
    chk("t5_resync", CW'(resync), '0);
    chk("t5_ddc_en", CW'(ddc_en), '0);
    tick();
    tick();
    rst_n  = 1'b1;
    tready = 1'b1;
    tick();
    start_commit();
    wait_en(100);
    chk_int("t5_nbeats", obs_q.size(), N_CH);
    if (obs_q.size() > 0) chk("t5_beat0", CW'(obs_q[0]), '0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      cfg_wr_en = ($urandom_range(0, 2) == 0);
      cfg_ch    = CH_W'($urandom_range(0, N_CH - 1));
      cfg_pinc  = $urandom;
      cfg_poff  = $urandom;
      commit    = ($urandom_range(0, 39) == 0);
      tready    = ($urandom_range(0, 3) != 0);
      tick();
    end
    cfg_wr_en = 1'b0;
    commit    = 1'b0;
    tready    = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk_int("rand_quiesce", busy ? 1 : 0, 0);
    chk_int("rand_exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
